// File: rtl/div_seq_if.sv
// div_seq_if: request/response bundle between the EX stage and the divide
// sequencer.
//   signed_div_i  1 = signed divide, 0 = unsigned
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held by EX until ready_o
//   annul_i       flush of an in-flight or pending divide
//   result_o      {remainder, quotient}
//   ready_o       result valid
//   stallreq_o    stall request to the pipeline controller
interface div_seq_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/div_seq.sv
// div_seq: multi-cycle signed/unsigned 32-bit restoring divider for EX.
// One quotient bit per cycle; holds the pipeline via stallreq_o while busy.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   bus   div_seq_if.slave (operands, start/annul in; result/ready/stall out)
module div_seq (
  input logic      clk,
  input logic      rst,
  div_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [5:0]  cnt, cnt_n;
  logic        ready_q, ready_n;
  logic [63:0] result_q, result_n;

  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dsr_q;
  logic        qneg_q;
  logic        rneg_q;

  logic        load;
  logic        step;
  logic [32:0] trial;

  // Unsigned magnitude of an operand; only negative values in signed mode
  // are folded. The most negative value maps onto itself, which is the
  // correct magnitude 2^31 when read as unsigned.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
    logic signed [31:0] sv;
    sv = $signed(v);
    if (sgn && (sv < 0))
      return 32'(-sv);
    return v;
  endfunction

  function automatic logic [31:0] apply_sign(input logic [31:0] v, input logic neg);
    logic signed [31:0] sv;
    sv = $signed(v);
    if (neg)
      return 32'(-sv);
    return v;
  endfunction

  // Trial subtract of the divisor from the shifted partial remainder.
  assign trial = {rem_q, quo_q[31]} - {1'b0, dsr_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= 6'd0;
      ready_q  <= 1'b0;
      result_q <= 64'h0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      ready_q  <= ready_n;
      result_q <= result_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    ready_n  = ready_q;
    result_n = result_q;
    load     = 1'b0;
    step     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          load    = 1'b1;
          cnt_n   = 6'd0;
          state_n = (bus.opdata2_i == 32'h0) ? ST_BYZERO : ST_ON;
        end
      end
      ST_BYZERO: begin
        if (bus.annul_i) begin
          state_n  = ST_IDLE;
          ready_n  = 1'b0;
          result_n = 64'h0;
        end else begin
          state_n  = ST_END;
          ready_n  = 1'b1;
          result_n = 64'h0;
        end
      end
      ST_ON: begin
        if (bus.annul_i) begin
          state_n  = ST_IDLE;
          cnt_n    = 6'd0;
          ready_n  = 1'b0;
          result_n = 64'h0;
        end else if (cnt == 6'd32) begin
          state_n  = ST_END;
          ready_n  = 1'b1;
          result_n = {apply_sign(rem_q, rneg_q), apply_sign(quo_q, qneg_q)};
        end else begin
          step  = 1'b1;
          cnt_n = cnt + 6'd1;
        end
      end
      ST_END: begin
        if (!bus.start_i || bus.annul_i) begin
          state_n  = ST_IDLE;
          ready_n  = 1'b0;
          result_n = 64'h0;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Datapath: operand capture at accept, one restoring step per iteration.
  always_ff @(posedge clk) begin
    if (load) begin
      rem_q  <= 32'h0;
      quo_q  <= magnitude(bus.opdata1_i, bus.signed_div_i);
      dsr_q  <= magnitude(bus.opdata2_i, bus.signed_div_i);
      qneg_q <= bus.signed_div_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
      rneg_q <= bus.signed_div_i & bus.opdata1_i[31];
    end else if (step) begin
      if (!trial[32]) begin
        rem_q <= trial[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= {rem_q[30:0], quo_q[31]};
        quo_q <= {quo_q[30:0], 1'b0};
      end
    end
  end

  assign bus.result_o   = result_q;
  assign bus.ready_o    = ready_q;
  assign bus.stallreq_o = bus.start_i & ~bus.annul_i & (state != ST_END);

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed test of div_seq with a cycle-level reference model
// and literal result checks.
module tb_div_seq;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  div_seq_if bus_if ();

  div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    if (b == 32'h0) return 64'h0;
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = a;
      y = b;
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // Reference: idle -> busy for a fixed number of edges -> done.
  int          m_phase;
  int          m_left;
  logic [63:0] m_res;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase <= 0;
      m_left  <= 0;
      m_res   <= 64'h0;
    end else begin
      case (m_phase)
        0: if (bus_if.start_i && !bus_if.annul_i) begin
             m_res   <= ref_div(bus_if.signed_div_i, bus_if.opdata1_i, bus_if.opdata2_i);
             m_left  <= (bus_if.opdata2_i == 32'h0) ? 1 : 33;
             m_phase <= 1;
           end
        1: if (bus_if.annul_i) m_phase <= 0;
           else if (m_left == 1) m_phase <= 2;
           else m_left <= m_left - 1;
        default: if (!bus_if.start_i || bus_if.annul_i) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("model_ready", {63'h0, bus_if.ready_o}, {63'h0, (m_phase == 2)});
      chk("model_result", bus_if.result_o, (m_phase == 2) ? m_res : 64'h0);
      chk("model_stall", {63'h0, bus_if.stallreq_o},
          {63'h0, bus_if.start_i & ~bus_if.annul_i & (m_phase != 2)});
    end
  end

  task automatic run_div(input string name, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] lit,
                         input int lat, input int hold);
    int n;
    bit got;
    bus_if.signed_div_i = sgn;
    bus_if.opdata1_i    = a;
    bus_if.opdata2_i    = b;
    bus_if.annul_i      = 1'b0;
    bus_if.start_i      = 1'b1;
    n   = 0;
    got = 0;
    while (n < 60 && !got) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        bus_if.opdata1_i = $urandom;
        bus_if.opdata2_i = $urandom;
      end
      if (bus_if.ready_o) got = 1;
    end
    chk({name, "_latency"}, 64'(n), 64'(lat));
    chk({name, "_result"}, bus_if.result_o, lit);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({name, "_hold_result"}, bus_if.result_o, lit);
      chk({name, "_hold_ready"}, {63'h0, bus_if.ready_o}, 64'h1);
      chk({name, "_hold_stall"}, {63'h0, bus_if.stallreq_o}, 64'h0);
    end
    bus_if.start_i = 1'b0;
    @(posedge clk); #1;
    chk({name, "_drop_ready"}, {63'h0, bus_if.ready_o}, 64'h0);
    chk({name, "_drop_result"}, bus_if.result_o, 64'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    bus_if.signed_div_i = 1'b0;
    bus_if.opdata1_i    = 32'h0;
    bus_if.opdata2_i    = 32'h0;
    bus_if.start_i      = 1'b0;
    bus_if.annul_i      = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("reset_ready", {63'h0, bus_if.ready_o}, 64'h0);
    chk("reset_result", bus_if.result_o, 64'h0);
    chk("reset_stall", {63'h0, bus_if.stallreq_o}, 64'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;

    run_div("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34, 1);
    run_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 34, 0);
    run_div("s_7_m2", 1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34, 0);
    run_div("u_fff9_2", 1'b0, 32'hFFFFFFF9, 32'h00000002, 64'h00000001_7FFFFFFC, 34, 0);
    run_div("div0", 1'b0, 32'h00001234, 32'h0, 64'h0, 2, 2);

    // Annul a divide in flight.
    bus_if.signed_div_i = 1'b0;
    bus_if.opdata1_i    = 32'd100;
    bus_if.opdata2_i    = 32'd7;
    bus_if.start_i      = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    bus_if.annul_i = 1'b1;
    #1 chk("annul_stall", {63'h0, bus_if.stallreq_o}, 64'h0);
    @(posedge clk); #1;
    bus_if.annul_i = 1'b0;
    bus_if.start_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      chk("annul_no_ready", {63'h0, bus_if.ready_o}, 64'h0);
    end
    run_div("u9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34, 0);

    // Asynchronous reset mid-divide.
    bus_if.signed_div_i = 1'b1;
    bus_if.opdata1_i    = 32'hFFFFFFF9;
    bus_if.opdata2_i    = 32'h00000002;
    bus_if.start_i      = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_ready", {63'h0, bus_if.ready_o}, 64'h0);
    chk("rst_mid_result", bus_if.result_o, 64'h0);
    @(posedge clk); #1;
    bus_if.start_i = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset while a result is being held.
    bus_if.signed_div_i = 1'b0;
    bus_if.opdata1_i    = 32'd100;
    bus_if.opdata2_i    = 32'd7;
    bus_if.start_i      = 1'b1;
    begin
      int n;
      n = 0;
      while (n < 60 && !bus_if.ready_o) begin @(posedge clk); #1; n++; end
      chk("rst_end_pre", bus_if.result_o, 64'h00000002_0000000E);
    end
    #2 rst = 1'b0;
    #1;
    chk("rst_end_ready", {63'h0, bus_if.ready_o}, 64'h0);
    chk("rst_end_result", bus_if.result_o, 64'h0);
    bus_if.start_i = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;

    run_div("u_ffff_1", 1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF, 34, 0);
    run_div("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
